// File: rtl/dlc_async_pkg.sv
// dlc_async_filt shared definitions
// stage limits, counter width helper, edge kinds
package dlc_async_pkg;

  localparam int DLC_ASYNC_MIN_STAGES = 2;
  localparam int DLC_ASYNC_MAX_STAGES = 4;

  typedef enum logic [1:0] {
    NONE,
    RISE,
    FALL
  } edge_t;

  // Filter counter width: max(1, clog2(FILT_CNT+1))
  function automatic int dlc_async_cnt_w(input int filt_cnt);
    return (filt_cnt < 1) ? 1 : $clog2(filt_cnt + 1);
  endfunction

endpackage

// File: rtl/dlc_async_filt_bit.sv
// dlc_async_filt single-bit slice
// sync chain, stability counter, q and edge pulses
module dlc_async_filt_bit
  import dlc_async_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter int   FILT_CNT = 0,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int            CW   = dlc_async_cnt_w(FILT_CNT);
  localparam logic [CW-1:0] CMAX = CW'(FILT_CNT);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  logic          s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  assign s    = sync_q[STAGES-1];
  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

  // Shift chain; stage 1 samples the raw asynchronous input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {STAGES{RST_BIT}};
    else       sync_q <= {sync_q[STAGES-2:0], din};
  end

  // Accept s only after it differs from q for FILT_CNT+1 samples
  always_comb begin
    cnt_d  = '0;
    q_d    = q_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != q_q) begin
      if (cnt_q == CMAX) begin
        q_d    = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state; reset drops any count in flight without a pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      q_q    <= RST_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

endmodule

// File: rtl/dlc_async_filt.sv
// dlc_async_filt: multi-bit filtered synchroniser
// optional sticky change flags under DLC_ASYNC_STICKY_EN
module dlc_async_filt
  import dlc_async_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter int               FILT_CNT  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_chg
`ifdef DLC_ASYNC_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] sticky
`endif
);

  if (STAGES < DLC_ASYNC_MIN_STAGES ||
      STAGES > DLC_ASYNC_MAX_STAGES) begin : g_bad_stages
    $error("dlc_async_filt: STAGES must be 2..4");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dlc_async_filt_bit #(
      .STAGES  (STAGES),
      .FILT_CNT(FILT_CNT),
      .RST_BIT (RESET_VAL[i])
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .din  (din[i]),
      .q    (q[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign any_chg = |(rise | fall);

`ifdef DLC_ASYNC_STICKY_EN
  logic [WIDTH-1:0] sticky_q;

  assign sticky = sticky_q;

  // Sticky change flags; a new pulse beats a coincident clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= (sticky_q & ~{WIDTH{sticky_clr}}) | rise | fall;
  end
`endif

endmodule

// File: tb/tb_dlc_async_filt.sv
// tb_dlc_async_filt: scoreboard bench, two configs
// A: STAGES=3 FILT=0; B: STAGES=2 FILT=3 RESET_VAL=A0
module tb_dlc_async_filt;
  import dlc_async_pkg::*;

  localparam int W = 8;

  typedef struct {
    int           cyc;
    logic [W-1:0] q;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din_a = 8'h00;
  logic [W-1:0] din_b = 8'hA0;
  logic [W-1:0] q_a, rise_a, fall_a;
  logic [W-1:0] q_b, rise_b, fall_b;
  logic         chg_a, chg_b;
`ifdef DLC_ASYNC_STICKY_EN
  logic         clr_a = 1'b0;
  logic         clr_b = 1'b0;
  logic [W-1:0] st_a, st_b;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t qa[$];
  exp_t qb[$];

  dlc_async_filt #(
    .WIDTH(W), .STAGES(3), .FILT_CNT(0), .RESET_VAL(8'h00)
  ) dut_a (
    .clk(clk), .reset(reset), .din(din_a),
    .q(q_a), .rise(rise_a), .fall(fall_a), .any_chg(chg_a)
`ifdef DLC_ASYNC_STICKY_EN
    , .sticky_clr(clr_a), .sticky(st_a)
`endif
  );

  dlc_async_filt #(
    .WIDTH(W), .STAGES(2), .FILT_CNT(3), .RESET_VAL(8'hA0)
  ) dut_b (
    .clk(clk), .reset(reset), .din(din_b),
    .q(q_b), .rise(rise_b), .fall(fall_b), .any_chg(chg_b)
`ifdef DLC_ASYNC_STICKY_EN
    , .sticky_clr(clr_b), .sticky(st_b)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic edge_t edge_of(input logic o, input logic n);
    if (o == n) return NONE;
    return n ? RISE : FALL;
  endfunction

  task automatic push(input bit b, input int c,
                      input logic [W-1:0] o, input logic [W-1:0] n);
    exp_t e;
    e.cyc  = c;
    e.q    = n;
    e.rise = '0;
    e.fall = '0;
    for (int i = 0; i < W; i++) begin
      edge_t k;
      k = edge_of(o[i], n[i]);
      e.rise[i] = (k == RISE);
      e.fall[i] = (k == FALL);
    end
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && chg_a) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected cyc=%0d q=%0h required=no_event",
                 cyc, q_a);
      end else begin
        e = qa.pop_front();
        chk("a_cyc", cyc, e.cyc);
        chk("a_q", {24'd0, q_a}, {24'd0, e.q});
        chk("a_rise", {24'd0, rise_a}, {24'd0, e.rise});
        chk("a_fall", {24'd0, fall_a}, {24'd0, e.fall});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && chg_b) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected cyc=%0d q=%0h required=no_event",
                 cyc, q_b);
      end else begin
        e = qb.pop_front();
        chk("b_cyc", cyc, e.cyc);
        chk("b_q", {24'd0, q_b}, {24'd0, e.q});
        chk("b_rise", {24'd0, rise_b}, {24'd0, e.rise});
        chk("b_fall", {24'd0, fall_b}, {24'd0, e.fall});
      end
    end
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_q_a", {24'd0, q_a}, 32'h00);
    chk("rst_q_b", {24'd0, q_b}, 32'hA0);
    chk("rst_pulse_b", {16'd0, rise_b, fall_b}, 32'h0);
    chk("rst_chg", {30'd0, chg_a, chg_b}, 32'h0);
`ifdef DLC_ASYNC_STICKY_EN
    chk("rst_sticky", {24'd0, st_a}, 32'h0);
`endif
    tick(2);
    reset = 1'b0;
    tick(2);

    din_a = 8'h01; push(0, cyc + 4, 8'h00, 8'h01); tick(8);
    din_a = 8'h00; push(0, cyc + 4, 8'h01, 8'h00); tick(8);
    din_a = 8'hF0; push(0, cyc + 4, 8'h00, 8'hF0); tick(8);
    din_a = 8'h0F; push(0, cyc + 4, 8'hF0, 8'h0F); tick(8);

    din_b = 8'hA2; tick(3);
    din_b = 8'hA0; tick(10);
    chk("glitch_q_b", {24'd0, q_b}, 32'hA0);

    din_b = 8'hA2; push(1, cyc + 6, 8'hA0, 8'hA2); tick(10);

    din_b = 8'hA3; tick(3);
    din_b = 8'hA2; tick(1);
    din_b = 8'hA3; push(1, cyc + 6, 8'hA2, 8'hA3); tick(10);

    din_a = 8'h00;
    din_b = 8'hA0;
    tick(3);
    reset = 1'b1;
    #1;
    chk("midrst_q_a", {24'd0, q_a}, 32'h00);
    chk("midrst_q_b", {24'd0, q_b}, 32'hA0);
    chk("midrst_pulse", {16'd0, rise_b, fall_b}, 32'h0);
    chk("midrst_chg", {30'd0, chg_a, chg_b}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(10);

`ifdef DLC_ASYNC_STICKY_EN
    din_a = 8'h04; push(0, cyc + 4, 8'h00, 8'h04); tick(4);
    tick(1);
    chk("sticky_set", {24'd0, st_a}, 32'h04);
    tick(3);
    din_a = 8'h00; push(0, cyc + 4, 8'h04, 8'h00); tick(4);
    clr_a = 1'b1; tick(1); clr_a = 1'b0;
    chk("sticky_setwins", {24'd0, st_a}, 32'h04);
    clr_a = 1'b1; tick(1); clr_a = 1'b0;
    chk("sticky_clr", {24'd0, st_a}, 32'h00);
    tick(4);
`endif

    tick(5);
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    chk("end_q_a", {24'd0, q_a}, 32'h00);
    chk("end_q_b", {24'd0, q_b}, 32'hA0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
